// File: rtl/led_pattern_blinker.sv
// Multi-channel programmable LED blink engine driven by a shared TICK_HZ time base.
// Build option LED_BLINKER_FAST_TICK_EN removes the prescaler and ticks on every CLK cycle.
module led_pattern_blinker #(
   parameter int CLK_HZ   = 16000000,
   parameter int TICK_HZ  = 1000,
   parameter int CHANNELS = 4,
   parameter int PERIOD_W = 16,
   parameter int COUNT_W  = 8,
   localparam int CH_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                CLK,
   input  logic                RST_N,
   input  logic                CFG_WE,
   input  logic [CH_W-1:0]     CFG_CH,
   input  logic [1:0]          CFG_MODE,
   input  logic [PERIOD_W-1:0] CFG_PERIOD,
   input  logic [PERIOD_W-1:0] CFG_ON,
   input  logic [COUNT_W-1:0]  CFG_COUNT,
   output logic [CHANNELS-1:0] LED,
   output logic [CHANNELS-1:0] BUSY,
   output logic                TICK
);

   localparam int DIV = CLK_HZ / TICK_HZ;

   typedef enum logic [1:0] {
      MODE_OFF   = 2'd0,
      MODE_ON    = 2'd1,
      MODE_BLINK = 2'd2,
      MODE_BURST = 2'd3
   } mode_e;

   if (DIV < 2) begin : g_bad_div
      $error("led_pattern_blinker: CLK_HZ/TICK_HZ must be at least 2");
   end
   if ((CHANNELS < 1) || (CHANNELS > 16)) begin : g_bad_channels
      $error("led_pattern_blinker: CHANNELS must be in 1..16");
   end

   function automatic logic [PERIOD_W-1:0] eff_period_f(input logic [PERIOD_W-1:0] p);
      if (p == {PERIOD_W{1'b0}}) begin
         eff_period_f = PERIOD_W'(1);
      end else begin
         eff_period_f = p;
      end
   endfunction

   function automatic logic led_f(input mode_e m, input logic [PERIOD_W-1:0] ph,
                                  input logic [PERIOD_W-1:0] on_t, input logic [COUNT_W-1:0] rem);
      case (m)
         MODE_ON:    led_f = 1'b1;
         MODE_BLINK: led_f = (ph < on_t);
         MODE_BURST: led_f = (ph < on_t) && (rem != {COUNT_W{1'b0}});
         default:    led_f = 1'b0;
      endcase
   endfunction

   function automatic logic busy_f(input mode_e m, input logic [COUNT_W-1:0] rem);
      case (m)
         MODE_BLINK: busy_f = 1'b1;
         MODE_BURST: busy_f = (rem != {COUNT_W{1'b0}});
         default:    busy_f = 1'b0;
      endcase
   endfunction

   logic tick_r;

`ifdef LED_BLINKER_FAST_TICK_EN
   // time base: every cycle is a tick once out of reset
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         tick_r <= 1'b0;
      end else begin
         tick_r <= 1'b1;
      end
   end
`else
   localparam int DIV_W = (DIV > 2) ? $clog2(DIV) : 1;

   logic [DIV_W-1:0] presc_r;

   // prescaler 0..DIV-1; tick_r is raised for the cycle in which the count sits at DIV-1
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         presc_r <= {DIV_W{1'b0}};
         tick_r  <= 1'b0;
      end else begin
         if (presc_r == DIV_W'(DIV - 1)) begin
            presc_r <= {DIV_W{1'b0}};
         end else begin
            presc_r <= presc_r + DIV_W'(1);
         end
         tick_r <= (presc_r == DIV_W'(DIV - 2));
      end
   end
`endif

   assign TICK = tick_r;

   for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
      mode_e               mode_r, mode_s;
      logic [PERIOD_W-1:0] period_r, period_s;
      logic [PERIOD_W-1:0] on_r, on_s;
      logic [PERIOD_W-1:0] phase_r, phase_s;
      logic [PERIOD_W-1:0] per_eff_s;
      logic [COUNT_W-1:0]  rem_r, rem_s;
      logic                sel_s;
      logic                wrap_s;
      logic                led_r;
      logic                busy_r;

      assign sel_s = CFG_WE && (CFG_CH == CH_W'(g));

      // next channel state; a write to this channel overrides a coincident tick
      always_comb begin
         mode_s    = mode_r;
         period_s  = period_r;
         on_s      = on_r;
         phase_s   = phase_r;
         rem_s     = rem_r;
         per_eff_s = eff_period_f(period_r);
         wrap_s    = (phase_r == (per_eff_s - PERIOD_W'(1)));
         if (sel_s) begin
            period_s = CFG_PERIOD;
            on_s     = CFG_ON;
            phase_s  = {PERIOD_W{1'b0}};
            rem_s    = CFG_COUNT;
            if ((mode_e'(CFG_MODE) == MODE_BURST) && (CFG_COUNT == {COUNT_W{1'b0}})) begin
               mode_s = MODE_OFF;
            end else begin
               mode_s = mode_e'(CFG_MODE);
            end
         end else if (tick_r) begin
            case (mode_r)
               MODE_BLINK: begin
                  if (wrap_s) begin
                     phase_s = {PERIOD_W{1'b0}};
                  end else begin
                     phase_s = phase_r + PERIOD_W'(1);
                  end
               end
               MODE_BURST: begin
                  if (wrap_s) begin
                     phase_s = {PERIOD_W{1'b0}};
                     // the last period retires the channel on the same edge
                     if (rem_r <= COUNT_W'(1)) begin
                        rem_s  = {COUNT_W{1'b0}};
                        mode_s = MODE_OFF;
                     end else begin
                        rem_s = rem_r - COUNT_W'(1);
                     end
                  end else begin
                     phase_s = phase_r + PERIOD_W'(1);
                  end
               end
               default: phase_s = {PERIOD_W{1'b0}};
            endcase
         end else begin
            phase_s = phase_r;
         end
      end

      // channel FSM registers; LED/BUSY are decoded from the next state so they track the registers
      always_ff @(posedge CLK or negedge RST_N) begin
         if (!RST_N) begin
            mode_r   <= MODE_OFF;
            period_r <= {PERIOD_W{1'b0}};
            on_r     <= {PERIOD_W{1'b0}};
            phase_r  <= {PERIOD_W{1'b0}};
            rem_r    <= {COUNT_W{1'b0}};
            led_r    <= 1'b0;
            busy_r   <= 1'b0;
         end else begin
            mode_r   <= mode_s;
            period_r <= period_s;
            on_r     <= on_s;
            phase_r  <= phase_s;
            rem_r    <= rem_s;
            led_r    <= led_f(mode_s, phase_s, on_s, rem_s);
            busy_r   <= busy_f(mode_s, rem_s);
         end
      end

      assign LED[g]  = led_r;
      assign BUSY[g] = busy_r;
   end

endmodule

// File: tb/tb_led_pattern_blinker.sv
// Scoreboard bench for led_pattern_blinker with a 16-cycle tick and five channels.
`timescale 1ns/1ps
module tb_led_pattern_blinker;
   localparam int NCH  = 5;
   localparam int PW   = 16;
   localparam int CW   = 8;
   localparam int DIVT = 16;

   logic           CLK = 1'b0;
   logic           RST_N;
   logic           CFG_WE;
   logic [2:0]     CFG_CH;
   logic [1:0]     CFG_MODE;
   logic [PW-1:0]  CFG_PERIOD;
   logic [PW-1:0]  CFG_ON;
   logic [CW-1:0]  CFG_COUNT;
   logic [NCH-1:0] LED;
   logic [NCH-1:0] BUSY;
   logic           TICK;

   led_pattern_blinker #(
      .CLK_HZ(16), .TICK_HZ(1), .CHANNELS(NCH), .PERIOD_W(PW), .COUNT_W(CW)
   ) dut (
      .CLK(CLK), .RST_N(RST_N), .CFG_WE(CFG_WE), .CFG_CH(CFG_CH), .CFG_MODE(CFG_MODE),
      .CFG_PERIOD(CFG_PERIOD), .CFG_ON(CFG_ON), .CFG_COUNT(CFG_COUNT),
      .LED(LED), .BUSY(BUSY), .TICK(TICK)
   );

   always #5 CLK = ~CLK;

   int total_n = 0;
   int bad_n   = 0;
   int cyc_n   = 0;

   // reference model state
   int m_presc;
   bit m_tick;
   int m_mode [NCH];
   int m_per  [NCH];
   int m_on   [NCH];
   int m_ph   [NCH];
   int m_rem  [NCH];
   logic [2*NCH:0] exp_q[$];

   // edge tracking of observed outputs
   logic [NCH-1:0] prev_led  = '0;
   logic [NCH-1:0] prev_busy = '0;
   int rise_t [NCH][8];
   int fall_t [NCH][8];
   int bfall_t[NCH][8];
   int n_rise [NCH];
   int n_fall [NCH];
   int n_bfall[NCH];
   int tick_t [8];
   int n_tick;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total_n++;
      if (got !== exp) begin
         bad_n++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic model_reset();
      m_presc = 0;
      m_tick  = 1'b0;
      for (int c = 0; c < NCH; c++) begin
         m_mode[c] = 0; m_per[c] = 0; m_on[c] = 0; m_ph[c] = 0; m_rem[c] = 0;
      end
   endtask

   task automatic clear_track();
      for (int c = 0; c < NCH; c++) begin
         n_rise[c] = 0; n_fall[c] = 0; n_bfall[c] = 0;
         for (int k = 0; k < 8; k++) begin
            rise_t[c][k] = 0; fall_t[c][k] = 0; bfall_t[c][k] = 0;
         end
      end
      n_tick = 0;
      for (int k = 0; k < 8; k++) tick_t[k] = 0;
   endtask

   // advance the model over one clock edge with the inputs currently driven
   task automatic model_edge();
      logic [NCH-1:0] led_e;
      logic [NCH-1:0] busy_e;
      bit tk;
      tk = m_tick;
      for (int c = 0; c < NCH; c++) begin
         int pe;
         pe = (m_per[c] == 0) ? 1 : m_per[c];
         if (CFG_WE && (int'(CFG_CH) == c)) begin
            m_mode[c] = (CFG_MODE == 2'd3 && CFG_COUNT == 0) ? 0 : int'(CFG_MODE);
            m_per[c]  = int'(CFG_PERIOD);
            m_on[c]   = int'(CFG_ON);
            m_ph[c]   = 0;
            m_rem[c]  = int'(CFG_COUNT);
         end else if (tk && m_mode[c] >= 2) begin
            if (m_ph[c] + 1 >= pe) begin
               m_ph[c] = 0;
               if (m_mode[c] == 3) begin
                  m_rem[c]--;
                  if (m_rem[c] == 0) m_mode[c] = 0;
               end
            end else begin
               m_ph[c]++;
            end
         end
         case (m_mode[c])
            1:       begin led_e[c] = 1'b1; busy_e[c] = 1'b0; end
            2, 3:    begin led_e[c] = (m_ph[c] < m_on[c]); busy_e[c] = 1'b1; end
            default: begin led_e[c] = 1'b0; busy_e[c] = 1'b0; end
         endcase
      end
      m_presc = (m_presc + 1) % DIVT;
      m_tick  = (m_presc == DIVT - 1);
      exp_q.push_back({m_tick, busy_e, led_e});
   endtask

   task automatic cyc();
      logic [2*NCH:0] got;
      logic [2*NCH:0] e;
      model_edge();
      @(posedge CLK);
      #1;
      cyc_n++;
      got = {TICK, BUSY, LED};
      e   = exp_q.pop_front();
      check_eq($sformatf("cycle%0d", cyc_n), 32'(got), 32'(e));
      for (int c = 0; c < NCH; c++) begin
         if (LED[c] === 1'b1 && prev_led[c] === 1'b0 && n_rise[c] < 8) begin
            rise_t[c][n_rise[c]] = cyc_n; n_rise[c]++;
         end
         if (LED[c] === 1'b0 && prev_led[c] === 1'b1 && n_fall[c] < 8) begin
            fall_t[c][n_fall[c]] = cyc_n; n_fall[c]++;
         end
         if (BUSY[c] === 1'b0 && prev_busy[c] === 1'b1 && n_bfall[c] < 8) begin
            bfall_t[c][n_bfall[c]] = cyc_n; n_bfall[c]++;
         end
      end
      if (TICK === 1'b1 && n_tick < 8) begin
         tick_t[n_tick] = cyc_n; n_tick++;
      end
      prev_led  = LED;
      prev_busy = BUSY;
   endtask

   task automatic cfg_write(input int ch, input int md, input int per, input int on, input int cnt);
      CFG_WE     = 1'b1;
      CFG_CH     = 3'(ch);
      CFG_MODE   = 2'(md);
      CFG_PERIOD = PW'(per);
      CFG_ON     = PW'(on);
      CFG_COUNT  = CW'(cnt);
      cyc();
      CFG_WE     = 1'b0;
   endtask

   // run until the current cycle carries a tick, so the next edge is a tick edge
   task automatic wait_tick();
      for (int i = 0; i < 2 * DIVT && !m_tick; i++) cyc();
      check_eq("tick_wait", 32'(TICK), 32'd1);
   endtask

   int w0, w1, w3, n_bad, n_rises;

   initial begin
      RST_N = 1'b0; CFG_WE = 1'b0; CFG_CH = '0; CFG_MODE = '0;
      CFG_PERIOD = '0; CFG_ON = '0; CFG_COUNT = '0;
      model_reset();
      clear_track();
      repeat (3) @(posedge CLK);
      #1;
      check_eq("rst_led",  32'(LED),  32'd0);
      check_eq("rst_busy", 32'(BUSY), 32'd0);
      check_eq("rst_tick", 32'(TICK), 32'd0);
      RST_N = 1'b1;

      // tick spacing straight out of reset
      repeat (40) cyc();
      check_eq("tick_count", n_tick, 2);
      check_eq("tick_first", tick_t[0], 15);
      check_eq("tick_gap",   tick_t[1] - tick_t[0], 16);

      // ch0 continuous blink, then ch1 three-period burst
      wait_tick();
      clear_track();
      cfg_write(0, 2, 4, 1, 0);
      w0 = cyc_n;
      wait_tick();
      cfg_write(1, 3, 2, 1, 3);
      w1 = cyc_n;
      repeat (120) cyc();
      check_eq("blink_start", rise_t[0][0], w0);
      check_eq("blink_high",  fall_t[0][0] - rise_t[0][0], 16);
      check_eq("blink_low",   rise_t[0][1] - fall_t[0][0], 48);
      check_eq("blink_busy",  32'(BUSY[0]), 32'd1);
      check_eq("burst_pulses", n_rise[1], 3);
      for (int k = 0; k < 3; k++)
         check_eq($sformatf("burst_width%0d", k), fall_t[1][k] - rise_t[1][k], 16);
      check_eq("burst_busy_fall", bfall_t[1][0] - w1, 96);
      check_eq("burst_mode_off", 32'(dut.g_ch[1].mode_r), 32'd0);

      // on >= period keeps LED lit; period 0 / on 0 keeps it dark
      cfg_write(2, 2, 4, 5, 0);
      n_bad = 0;
      repeat (64) begin cyc(); if (LED[2] !== 1'b1) n_bad++; end
      check_eq("on_ge_period", n_bad, 0);
      cfg_write(2, 2, 0, 0, 0);
      n_bad = 0;
      repeat (40) begin cyc(); if (LED[2] !== 1'b0) n_bad++; end
      check_eq("on_zero", n_bad, 0);
      check_eq("led_no_x", 32'($isunknown({LED, BUSY})), 32'd0);

      // write landing on a tick edge restarts ch3 at phase 0
      wait_tick();
      clear_track();
      cfg_write(3, 2, 2, 1, 0);
      w3 = cyc_n;
      repeat (40) cyc();
      check_eq("wr_tick_rise", rise_t[3][0], w3);
      check_eq("wr_tick_high", fall_t[3][0] - w3, 16);

      // out-of-range channel indices are ignored
      cfg_write(5, 1, 4, 4, 0);
      cfg_write(7, 1, 4, 4, 0);
      repeat (4) cyc();
      check_eq("oob_led4",  32'(LED[4]),  32'd0);
      check_eq("oob_busy4", 32'(BUSY[4]), 32'd0);

      // reset in the middle of a burst
      wait_tick();
      cfg_write(1, 3, 2, 1, 5);
      repeat (4) cyc();
      check_eq("pre_rst_led1", 32'(LED[1]), 32'd1);
      RST_N = 1'b0;
      #1;
      check_eq("rst_async_led",  32'(LED),  32'd0);
      check_eq("rst_async_busy", 32'(BUSY), 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      model_reset();
      RST_N = 1'b1;
      prev_led  = LED;
      prev_busy = BUSY;
      clear_track();
      repeat (100) cyc();
      n_rises = 0;
      for (int c = 0; c < NCH; c++) n_rises += n_rise[c];
      check_eq("post_rst_pulses", n_rises, 0);
      check_eq("post_rst_busy", 32'(BUSY), 32'd0);

      $display("test done: total=%0d bad=%0d", total_n, bad_n);
      $finish;
   end

endmodule

// File: doc/led_pattern_blinker.md
Name: led_pattern_blinker

Overview:
- Multi-channel programmable LED blink engine; the parametrised successor to the fixed 1 Hz single-LED blinker.
- A shared prescaler divides CLK down to a TICK_HZ time base.
- Each channel has its own mode, period, on-time and burst count, loaded through a simple write strobe.
- Drives board LEDs and status directly from the top level.

Parameters:
- CLK_HZ, 16000000, input clock frequency in Hz.
- TICK_HZ, 1000, time-base tick rate in Hz; DIV = CLK_HZ/TICK_HZ must be >= 2, else elaboration error.
- CHANNELS, 4, number of independent LED channels (1..16).
- PERIOD_W, 16, width of period and on-time fields, in ticks.
- COUNT_W, 8, width of the burst count field.

Ports:
- CLK  input  1  system clock.
- RST_N  input  1  asynchronous active-low reset.
- CFG_WE  input  1  config write strobe, sampled on posedge CLK.
- CFG_CH  input  max(1,$clog2(CHANNELS))  target channel index.
- CFG_MODE  input  2  0=OFF, 1=ON, 2=BLINK (continuous), 3=BURST.
- CFG_PERIOD  input  PERIOD_W  blink period in ticks.
- CFG_ON  input  PERIOD_W  on-time in ticks.
- CFG_COUNT  input  COUNT_W  number of periods for BURST mode.
- LED  output  CHANNELS  LED drive, 1 = lit.
- BUSY  output  CHANNELS  channel in BLINK, or in BURST with periods remaining.
- TICK  output  1  one-cycle pulse per time-base tick.

Behaviour:
- One clock domain. RST_N low asynchronously clears everything: prescaler=0, TICK=0, all modes=OFF, phase=0, remaining=0, LED=0, BUSY=0. Release is synchronous to CLK.
- Prescaler: counts 0..DIV-1 and wraps. TICK=1 for exactly the one cycle in which the count equals DIV-1; TICK is registered.
- Config write (CFG_WE=1, CFG_CH<CHANNELS):
  - On the next edge, the channel stores mode, period, on-time and count.
  - phase is cleared to 0 and remaining is set to CFG_COUNT.
  - Writes with CFG_CH>=CHANNELS are ignored.
- Period 0 is treated as period 1.
- Per-channel state machine:
  - OFF: LED=0, BUSY=0, phase held at 0.
  - ON: LED=1, BUSY=0.
  - BLINK: on each TICK, phase <= (phase==period-1) ? 0 : phase+1. LED = (phase < on). BUSY=1.
  - BURST: same phase rule as BLINK. When phase wraps to 0, remaining decrements; if it becomes 0, mode <= OFF on that same edge. LED = (phase < on) while remaining>0. BUSY = (remaining != 0).
- CFG_COUNT=0 in BURST: the channel is idle on the next cycle (LED=0, BUSY=0); mode reads back as OFF.
- on >= period: LED is constantly 1 while active. on=0: LED is constantly 0 while active.
- LED and BUSY are decoded only from channel registers. A write becomes visible on LED/BUSY in the cycle after the write edge (1-cycle latency).
- Write and TICK to the same channel in the same cycle: the write wins; phase=0 and that tick is not counted for that channel. Other channels still advance.
- Channels are fully independent. Phase counters are never shared.
- Reset mid-burst: the channel returns to OFF immediately; no residual pulses.

Optional Feature:
- Macro: LED_BLINKER_FAST_TICK_EN.
- When defined, the prescaler is removed and TICK is held at 1 every cycle, so all period/on/count values are in CLK cycles. Intended for fast simulation and bring-up.
- When undefined, normal DIV-based prescaler as above.
- Port list is identical in both builds.

Test Plan:
- Params CLK_HZ=16, TICK_HZ=1 (DIV=16). Reset release -> TICK pulses exactly every 16 cycles, first at cycle 15; LED=0, BUSY=0 throughout.
- Ch0 BLINK, period=4, on=1 -> LED[0] high for 16 cycles, low for 48, repeating; BUSY[0]=1.
- Ch1 BURST, period=2, on=1, count=3 -> exactly 3 LED pulses of 16 cycles each; BUSY[1] falls on the third wrap edge and the mode reads OFF.
- Ch2 BLINK, on=5, period=4 -> LED[2] constantly 1. Then period=0, on=0 -> LED[2] constantly 0 with no X.
- Write to ch3 coincident with TICK -> ch3 phase=0 and does not advance on that tick; ch0 advances normally. Write with CFG_CH=CHANNELS -> no channel changes.
- Assert RST_N low mid-burst on ch1 -> LED and BUSY clear asynchronously in the same cycle; no pulses after release until a new config write.
